// File: rtl/birdsong_i2s_tx.sv
// ============================================================================
// Module      : birdsong_i2s_tx
// Description : Mono I2S transmitter with sample FIFO, BCLK divider and sticky
//               error flags. Optional macro BIRDSONG_I2S_UNDERRUN_REPEAT_EN
//               repeats the last sample on underrun instead of sending silence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module birdsong_i2s_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        clear_flags,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun,
    output logic        overflow
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

    logic [7:0]       div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic [15:0]      held_q, held_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      mem_q [FIFO_DEPTH];

    logic       w_tick, w_fall, w_pop, w_push, w_pop_data;
    logic       w_underrun_set, w_overflow_set;
    logic [4:0] w_pos;
    logic [3:0] w_idx;
    logic       w_slot_bit;

    assign sample_ready = (count_q < DEPTH_C);

    always_comb begin
        w_tick         = (div_q == DIV_LAST);
        w_fall         = w_tick && bclk_q;
        w_pop          = w_fall && (bit_cnt_q == 6'd63);
        w_push         = sample_valid && sample_ready;
        w_pop_data     = w_pop && (count_q != '0);
        w_underrun_set = w_pop && (count_q == '0);
        w_overflow_set = sample_valid && !sample_ready;
    end

    always_comb begin
        div_d      = w_tick ? 8'd0 : div_q + 8'd1;
        bclk_d     = w_tick ? ~bclk_q : bclk_q;
        bit_cnt_d  = w_fall ? bit_cnt_q + 6'd1 : bit_cnt_q;
        held_d     = held_q;
        wr_ptr_d   = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop_data ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;

        if (w_pop_data) begin
            held_d = mem_q[rd_ptr_q];
        end else if (w_underrun_set) begin
`ifdef BIRDSONG_I2S_UNDERRUN_REPEAT_EN
            held_d = held_q;
`else
            held_d = 16'h0000;
`endif
        end

        case ({w_push, w_pop_data})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A set event in the same cycle as clear_flags keeps the flag high.
        if (w_underrun_set)   underrun_d = 1'b1;
        else if (clear_flags) underrun_d = 1'b0;
        if (w_overflow_set)   overflow_d = 1'b1;
        else if (clear_flags) overflow_d = 1'b0;

        // Slot bit 0 is the I2S one-bit delay; bits 1..16 carry MSB first.
        w_pos      = bit_cnt_d[4:0];
        w_idx      = 4'(5'd16 - w_pos);
        w_slot_bit = ((w_pos != 5'd0) && (w_pos <= 5'd16)) ? held_d[w_idx] : 1'b0;
        lrclk_d    = w_fall ? bit_cnt_d[5] : lrclk_q;
        sdata_d    = w_fall ? w_slot_bit : sdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= 8'd0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 6'd63;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            held_q     <= 16'h0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            held_q     <= held_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_birdsong_i2s_tx.sv
// Testbench for birdsong_i2s_tx: table-driven frame vectors plus directed
// sequences for overflow, pop/push collision, mid-frame reset and flag clearing.
`default_nettype none

module tb_birdsong_i2s_tx;

    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 128 * CLK_DIV;
    localparam int NVEC       = 8;
`ifdef BIRDSONG_I2S_UNDERRUN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        clear_flags = 1'b0;
    logic        bclk, lrclk, sdata, underrun, overflow;

    always #5 clk = ~clk;

    birdsong_i2s_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .clear_flags  (clear_flags),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    int checks   = 0;
    int failures = 0;
    int pad_err  = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Codec-side receiver: samples sdata on each BCLK rise, frames on lrclk.
    logic [15:0] capL[$];
    logic [15:0] capR[$];
    logic        m_prev_bclk, m_prev_lr;
    int          m_pos;
    logic [15:0] m_sh;

    initial begin
        m_prev_bclk = 1'b0;
        m_prev_lr   = 1'b1;
        m_pos       = 32;
        m_sh        = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_prev_bclk = 1'b0;
                m_prev_lr   = 1'b1;
                m_pos       = 32;
            end else begin
                if (bclk && !m_prev_bclk) begin
                    if (lrclk != m_prev_lr) m_pos = 0;
                    else                    m_pos = m_pos + 1;
                    m_prev_lr = lrclk;
                    if (m_pos >= 1 && m_pos <= 16) m_sh = {m_sh[14:0], sdata};
                    else if (m_pos <= 31 && sdata) pad_err = pad_err + 1;
                    if (m_pos == 16) begin
                        if (lrclk) capR.push_back(m_sh);
                        else       capL.push_back(m_sh);
                    end
                end
                m_prev_bclk = bclk;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bclk"},     32'(bclk),         32'd0);
        chk({tag, "_lrclk"},    32'(lrclk),        32'd1);
        chk({tag, "_sdata"},    32'(sdata),        32'd0);
        chk({tag, "_ready"},    32'(sample_ready), 32'd1);
        chk({tag, "_underrun"}, 32'(underrun),     32'd0);
        chk({tag, "_overflow"}, 32'(overflow),     32'd0);
    endtask

    task automatic push1(input logic [15:0] d);
        @(negedge clk);
        sample_in    = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    task automatic wait_frame_start(output int t);
        logic prev;
        bit   found;
        prev  = lrclk;
        found = 1'b0;
        t     = 0;
        for (int n = 0; n < 3 * FRAME_CYC; n++) begin
            @(negedge clk);
            if (prev && !lrclk) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
            prev = lrclk;
        end
        if (!found) chk("frame_start_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_caps(input int nl, input int nr, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8 * FRAME_CYC; n++) begin
            if (capL.size() > nl && capR.size() > nr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("capture_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic        push;
        logic [15:0] sample;
        logic [15:0] exp_word;
        logic        exp_unf;
        logic        clr_after;
    } vec_t;

    vec_t        vecs[NVEC];
    logic [15:0] burst[5];
    logic [15:0] burst_exp[6];

    initial begin
        int   t, tprev, nl, nr, first_rise, first_fall;
        bit   ok;
        logic prev_lr;

        vecs[0] = '{1'b1, 16'h8001, 16'h8001, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, REPEAT ? 16'h1234 : 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h7FFE, 16'h7FFE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, REPEAT ? 16'hA5C3 : 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0};
        burst     = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};
        burst_exp = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h6006,
                      REPEAT ? 16'h6006 : 16'h0000};

        // Reset state, then table of per-frame samples.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b1;
        push1(vecs[0].sample);
        tprev = 0;
        for (int i = 0; i < NVEC; i++) begin
            wait_frame_start(t);
            if (i == 1) chk("frame_len", 32'(t - tprev), 32'(FRAME_CYC));
            tprev = t;
            nl = capL.size();
            nr = capR.size();
            if (i + 1 < NVEC && vecs[i + 1].push) push1(vecs[i + 1].sample);
            wait_caps(nl, nr, ok);
            if (ok) begin
                chk($sformatf("vec%0d_left", i),  32'(capL[nl]), 32'(vecs[i].exp_word));
                chk($sformatf("vec%0d_right", i), 32'(capR[nr]), 32'(vecs[i].exp_word));
            end
            chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_unf));
            if (vecs[i].clr_after) pulse_clear();
        end
        chk("overflow_idle", 32'(overflow), 32'd0);

        // Five back-to-back pushes into an empty FIFO right after a pop.
        wait_frame_start(t);
        for (int k = 0; k < 5; k++) begin
            sample_in    = burst[k];
            sample_valid = 1'b1;
            chk($sformatf("burst%0d_ready", k), 32'(sample_ready), 32'(k < 4));
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("burst_overflow", 32'(overflow), 32'd1);

        // Hold valid high while full: acceptance must follow the pop cycle.
        sample_in    = 16'h6006;
        sample_valid = 1'b1;
        prev_lr      = lrclk;
        ok           = 1'b0;
        for (int n = 0; n < 2 * FRAME_CYC; n++) begin
            if (sample_ready) begin
                chk("ready_rises_at_pop", 32'({prev_lr, lrclk}), 32'b10);
                ok = 1'b1;
                break;
            end
            prev_lr = lrclk;
            @(negedge clk);
        end
        if (!ok) chk("hold_timeout", 32'd1, 32'd0);
        nl = capL.size();
        @(negedge clk);
        sample_valid = 1'b0;
        for (int n = 0; n < 8 * FRAME_CYC; n++) begin
            if (capL.size() >= nl + 6) break;
            @(negedge clk);
        end
        if (capL.size() >= nl + 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("fifo_order%0d", k), 32'(capL[nl + k]), 32'(burst_exp[k]));
        end else begin
            chk("fifo_order_timeout", 32'd1, 32'd0);
        end

        // Reset mid-frame (around bit 20) with a sample waiting in the FIFO.
        wait_frame_start(t);
        push1(16'hBEEF);
        repeat (77) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        first_rise = 0;
        first_fall = 0;
        for (int n = 1; n <= 2 * CLK_DIV + 1; n++) begin
            clear_flags = (n >= 2 * CLK_DIV);
            @(posedge clk);
            #1;
            if (bclk && first_rise == 0)   first_rise = n;
            if (!lrclk && first_fall == 0) first_fall = n;
            if (n == 2 * CLK_DIV)     chk("underrun_set_wins", 32'(underrun), 32'd1);
            if (n == 2 * CLK_DIV + 1) chk("underrun_cleared",  32'(underrun), 32'd0);
        end
        clear_flags = 1'b0;
        chk("first_bclk_rise", 32'(first_rise), 32'(CLK_DIV));
        chk("first_pop",       32'(first_fall), 32'(2 * CLK_DIV));
        @(negedge clk);
        nl = capL.size();
        nr = capR.size();
        wait_caps(nl, nr, ok);
        if (ok) chk("post_reset_word", 32'(capL[nl]), 32'h0);

        chk("padding_bits", 32'(pad_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/birdsong_i2s_tx.md
BIRDSONG_I2S_TX -- requirements
Module: birdsong_i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per BCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sample_in, input, 16 bits: signed Q1.15 processed sample from the gain/limiter stage.
REQ-006 SHALL have port sample_valid, input, 1 bit: sample_in is offered this cycle.
REQ-007 SHALL have port sample_ready, output, 1 bit: buffer can accept a sample this cycle.
REQ-008 SHALL have port clear_flags, input, 1 bit: synchronous clear of the sticky flags.
REQ-009 SHALL have ports bclk, lrclk and sdata, outputs, 1 bit each: I2S bit clock, word select and serial data to the codec.
REQ-010 SHALL have ports underrun and overflow, outputs, 1 bit each: sticky error flags.

Function
REQ-011 SHALL toggle bclk every CLK_DIV clk cycles from a divider counter, giving a BCLK period of 2*CLK_DIV clk cycles.
REQ-012 SHALL advance a 6-bit bit_cnt on each bclk falling edge (the clk cycle in which bclk goes 1->0), wrapping 63->0; lrclk and sdata SHALL update only in that cycle.
REQ-013 SHALL drive lrclk = 0 for bit_cnt 0..31 (left) and 1 for 32..63 (right).
REQ-014 SHALL use slot position p = bit_cnt mod 32: p=0 drives sdata=0 (I2S one-bit delay), p=1..16 drive held-sample bits 15 down to 0, and p=17..31 drive 0.
REQ-015 SHALL send the same held sample in both slots (mono duplicated to left and right).
REQ-016 SHALL pop the FIFO head into the held-sample register in the cycle bit_cnt wraps 63->0, so a popped sample first appears on sdata at bit_cnt=1.
REQ-017 SHALL implement the buffer as a FIFO_DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy counter 0..FIFO_DEPTH.
REQ-018 SHALL drive sample_ready = (occupancy < FIFO_DEPTH) combinationally from registered state; a push occurs when sample_valid && sample_ready.
REQ-019 SHALL leave occupancy unchanged on a simultaneous push and pop; a push with the FIFO full SHALL NOT occur, even if a pop happens in the same cycle.
REQ-020 SHALL discard sample_valid while full and set overflow.
REQ-021 SHALL set underrun and load the underrun substitute (see Configuration) when a pop occurs with occupancy 0.
REQ-022 SHALL clear underrun and overflow one cycle after clear_flags=1; if a set event coincides with clear_flags, the set SHALL win.
REQ-023 SHALL hold sample_in bits verbatim; no rounding or width change occurs.

Reset
REQ-024 SHALL, on rst=0 and asynchronously, drive: bclk=0, lrclk=1, sdata=0, bit_cnt=63, divider=0, FIFO empty, pointers=0, held sample=0, underrun=0, overflow=0.
REQ-025 SHALL produce the first bclk rise CLK_DIV cycles after rst deasserts, and the first fall (bit_cnt 63->0, first pop) 2*CLK_DIV cycles after rst deasserts.
REQ-026 SHALL, on a reset asserted mid-frame, abandon the frame and discard FIFO contents; no partial word resumes.

Configuration
REQ-027 SHALL, with macro BIRDSONG_I2S_UNDERRUN_REPEAT_EN defined, reload the previous held sample on underrun (repeat the last sample).
REQ-028 SHALL, without BIRDSONG_I2S_UNDERRUN_REPEAT_EN, load 16'h0000 on underrun (silence).
REQ-029 SHALL set the underrun flag identically in both builds.

Verification
REQ-030 SHALL cover: CLK_DIV=2, push 16'h8001 after reset -> sdata at p=1..16 is 1,0x14,1 in both slots, lrclk 0 then 1, frame = 256 clk cycles.
REQ-031 SHALL cover: 5 back-to-back pushes into an empty FIFO before the first pop -> 4 accepted, sample_ready=0 on the 5th, overflow=1, 5th value never appears.
REQ-032 SHALL cover: one push of 16'h1234, then none for 2 frames -> frame 2 shows underrun=1 and 16'h1234 with the macro, 16'h0000 without it.
REQ-033 SHALL cover: full FIFO with sample_valid held high across the pop cycle -> occupancy 4->3 at the pop, push accepted the next cycle, no data lost.
REQ-034 SHALL cover: rst pulsed low at bit_cnt=20 -> all outputs at reset values immediately, FIFO empty, first pop 2*CLK_DIV cycles after release.
REQ-035 SHALL cover: clear_flags=1 in the same cycle as an underrun pop -> underrun remains 1; clear_flags=1 alone the next cycle -> 0.
